decode_ctrl_pipe: RTL and testbench

Pipelined decode-control stage for the 5-stage RV32 core: decodes the ID-stage instruction into control signals and registers them through the ID/EX and EX/MEM control registers. Extends the single-cycle decoder with AUIPC, optional M-extension, illegal-opcode flagging, load-use stall detection, branch flush and downstream back-pressure. Sits between the IF/ID register and the EX/MEM datapath, alongside the forwarding unit.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 124 ++++++++++++
 rtl/decode_ctrl_pipe.sv | 110 +++++++++++
 tb/tb_decode_ctrl_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, ALUOp and InstType encodings plus control bundles for the decode-control pipe
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_I   = 3'b011;
    localparam logic [2:0] ALU_BR  = 3'b101;
    localparam logic [2:0] ALU_M   = 3'b110;

    localparam logic [2:0] IT_R = 3'b000;
    localparam logic [2:0] IT_I = 3'b001;
    localparam logic [2:0] IT_S = 3'b010;
    localparam logic [2:0] IT_B = 3'b011;
    localparam logic [2:0] IT_U = 3'b100;
    localparam logic [2:0] IT_J = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic       auipc;
        logic       illegal;
        logic [2:0] aluop;
        logic [2:0] insttype;
        logic [2:0] func3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic [4:0] rd;
    } mem_ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE = '0;
    localparam mem_ctrl_t MEM_BUBBLE  = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational RV32 decode into a control bundle plus source-register use flags
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_AUIPC = 1'b1,
    parameter bit ENABLE_MEXT  = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        use_rs1,
    output logic        use_rs2
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       legal;
    logic       raw_rs1;
    logic       raw_rs2;
    ctrl_t      raw;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];

    always_comb begin
        raw       = CTRL_BUBBLE;
        raw.valid = 1'b1;
        raw.func3 = instr[14:12];
        raw.rd    = instr[11:7];
        raw.rs1   = instr[19:15];
        raw.rs2   = instr[24:20];
        raw_rs1   = 1'b1;
        raw_rs2   = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OP_R: begin
                raw.regwrite = 1'b1;
                raw.insttype = IT_R;
                raw_rs2      = 1'b1;
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    raw.aluop = ALU_R;
                end else if (ENABLE_MEXT && funct7 == F7_MEXT) begin
                    raw.aluop = ALU_M;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_I: begin
                raw.aluop    = ALU_I;
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.insttype = IT_I;
            end
            OP_LOAD: begin
                raw.aluop    = ALU_ADD;
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.memread  = 1'b1;
                raw.memtoreg = 1'b1;
                raw.insttype = IT_I;
            end
            OP_STORE: begin
                raw.aluop    = ALU_ADD;
                raw.alusrc   = 1'b1;
                raw.memwrite = 1'b1;
                raw.insttype = IT_S;
                raw_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                raw.aluop    = ALU_BR;
                raw.branch   = 1'b1;
                raw.insttype = IT_B;
                raw_rs2      = 1'b1;
            end
            OP_LUI: begin
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.insttype = IT_U;
                raw_rs1      = 1'b0;
            end
            OP_AUIPC: begin
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.auipc    = 1'b1;
                raw.insttype = IT_U;
                raw_rs1      = 1'b0;
                legal        = ENABLE_AUIPC;
            end
            OP_JAL: begin
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.jump     = 1'b1;
                raw.insttype = IT_J;
                raw_rs1      = 1'b0;
            end
            OP_JALR: begin
                raw.alusrc   = 1'b1;
                raw.regwrite = 1'b1;
                raw.jump     = 1'b1;
                raw.insttype = IT_I;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions stay valid so the trap unit sees them, but drive no controls.
    always_comb begin
        ctrl    = raw;
        use_rs1 = legal & raw_rs1;
        use_rs2 = legal & raw_rs2;
        if (!legal) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.valid   = 1'b1;
            ctrl.illegal = 1'b1;
            ctrl.func3   = raw.func3;
            ctrl.rd      = raw.rd;
            ctrl.rs1     = raw.rs1;
            ctrl.rs2     = raw.rs2;
        end
        if (ctrl.rd == 5'd0) begin
            ctrl.regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - ID decode with load-use stall, flush and back-pressure into ID/EX and EX/MEM control registers
module decode_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_AUIPC = 1'b1,
    parameter bit ENABLE_MEXT  = 1'b1,
    parameter bit HAZARD_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [31:0] id_instr_i,
    input  logic        flush_i,
    input  logic        ex_ready_i,
    output logic        id_stall_o,
    output logic        ex_valid_o,
    output logic        ex_regwrite_o,
    output logic        ex_alusrc_o,
    output logic        ex_memread_o,
    output logic        ex_memwrite_o,
    output logic        ex_memtoreg_o,
    output logic        ex_branch_o,
    output logic        ex_jump_o,
    output logic        ex_auipc_o,
    output logic        ex_illegal_o,
    output logic [2:0]  ex_aluop_o,
    output logic [2:0]  ex_insttype_o,
    output logic [2:0]  ex_func3_o,
    output logic [4:0]  ex_rd_o,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output logic        mem_valid_o,
    output logic        mem_regwrite_o,
    output logic        mem_memread_o,
    output logic        mem_memwrite_o,
    output logic        mem_memtoreg_o,
    output logic [4:0]  mem_rd_o
);

    ctrl_t     id_ctrl;
    ctrl_t     ex_q;
    mem_ctrl_t mem_q;
    logic      id_use_rs1;
    logic      id_use_rs2;
    logic      rs1_hit;
    logic      rs2_hit;
    logic      hazard;

    ctrl_decode #(
        .ENABLE_AUIPC (ENABLE_AUIPC),
        .ENABLE_MEXT  (ENABLE_MEXT)
    ) u_decode (
        .instr   (id_instr_i),
        .ctrl    (id_ctrl),
        .use_rs1 (id_use_rs1),
        .use_rs2 (id_use_rs2)
    );

    assign rs1_hit = id_use_rs1 && (id_ctrl.rs1 == ex_q.rd);
    assign rs2_hit = id_use_rs2 && (id_ctrl.rs2 == ex_q.rd);
    assign hazard  = HAZARD_EN && id_valid_i && ex_q.valid && ex_q.memread &&
                     (ex_q.rd != 5'd0) && (rs1_hit || rs2_hit);

    // A flush kills the dependent instruction, so there is nothing left to stall for.
    assign id_stall_o = ~ex_ready_i | (hazard & ~flush_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= CTRL_BUBBLE;
            mem_q <= MEM_BUBBLE;
        end else if (ex_ready_i) begin
            mem_q.valid    <= ex_q.valid;
            mem_q.regwrite <= ex_q.regwrite;
            mem_q.memread  <= ex_q.memread;
            mem_q.memwrite <= ex_q.memwrite;
            mem_q.memtoreg <= ex_q.memtoreg;
            mem_q.rd       <= ex_q.rd;
            if (flush_i || hazard || !id_valid_i) begin
                ex_q <= CTRL_BUBBLE;
            end else begin
                ex_q <= id_ctrl;
            end
        end
    end

    assign ex_valid_o     = ex_q.valid;
    assign ex_regwrite_o  = ex_q.regwrite;
    assign ex_alusrc_o    = ex_q.alusrc;
    assign ex_memread_o   = ex_q.memread;
    assign ex_memwrite_o  = ex_q.memwrite;
    assign ex_memtoreg_o  = ex_q.memtoreg;
    assign ex_branch_o    = ex_q.branch;
    assign ex_jump_o      = ex_q.jump;
    assign ex_auipc_o     = ex_q.auipc;
    assign ex_illegal_o   = ex_q.illegal;
    assign ex_aluop_o     = ex_q.aluop;
    assign ex_insttype_o  = ex_q.insttype;
    assign ex_func3_o     = ex_q.func3;
    assign ex_rd_o        = ex_q.rd;
    assign ex_rs1_o       = ex_q.rs1;
    assign ex_rs2_o       = ex_q.rs2;

    assign mem_valid_o    = mem_q.valid;
    assign mem_regwrite_o = mem_q.regwrite;
    assign mem_memread_o  = mem_q.memread;
    assign mem_memwrite_o = mem_q.memwrite;
    assign mem_memtoreg_o = mem_q.memtoreg;
    assign mem_rd_o       = mem_q.rd;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb/tb_decode_ctrl_pipe.sv - scoreboard bench with randomized instruction stream and reference pipeline model
module tb_decode_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic       auipc;
        logic       illegal;
        logic [2:0] aluop;
        logic [2:0] insttype;
        logic [2:0] func3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_valid, a_flush, a_ready, a_stall;
    logic [31:0] a_instr;
    logic        a_ex_valid, a_ex_regwrite, a_ex_alusrc, a_ex_memread, a_ex_memwrite, a_ex_memtoreg;
    logic        a_ex_branch, a_ex_jump, a_ex_auipc, a_ex_illegal;
    logic [2:0]  a_ex_aluop, a_ex_insttype, a_ex_func3;
    logic [4:0]  a_ex_rd, a_ex_rs1, a_ex_rs2;
    logic        a_mem_valid, a_mem_regwrite, a_mem_memread, a_mem_memwrite, a_mem_memtoreg;
    logic [4:0]  a_mem_rd;

    logic        b_valid, b_flush, b_ready, b_stall;
    logic [31:0] b_instr;
    logic        b_ex_valid, b_ex_regwrite, b_ex_alusrc, b_ex_memread, b_ex_memwrite, b_ex_memtoreg;
    logic        b_ex_branch, b_ex_jump, b_ex_auipc, b_ex_illegal;
    logic [2:0]  b_ex_aluop, b_ex_insttype, b_ex_func3;
    logic [4:0]  b_ex_rd, b_ex_rs1, b_ex_rs2;
    logic        b_mem_valid, b_mem_regwrite, b_mem_memread, b_mem_memwrite, b_mem_memtoreg;
    logic [4:0]  b_mem_rd;

    decode_ctrl_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid_i(a_valid), .id_instr_i(a_instr),
        .flush_i(a_flush), .ex_ready_i(a_ready), .id_stall_o(a_stall),
        .ex_valid_o(a_ex_valid), .ex_regwrite_o(a_ex_regwrite), .ex_alusrc_o(a_ex_alusrc),
        .ex_memread_o(a_ex_memread), .ex_memwrite_o(a_ex_memwrite), .ex_memtoreg_o(a_ex_memtoreg),
        .ex_branch_o(a_ex_branch), .ex_jump_o(a_ex_jump), .ex_auipc_o(a_ex_auipc),
        .ex_illegal_o(a_ex_illegal), .ex_aluop_o(a_ex_aluop), .ex_insttype_o(a_ex_insttype),
        .ex_func3_o(a_ex_func3), .ex_rd_o(a_ex_rd), .ex_rs1_o(a_ex_rs1), .ex_rs2_o(a_ex_rs2),
        .mem_valid_o(a_mem_valid), .mem_regwrite_o(a_mem_regwrite), .mem_memread_o(a_mem_memread),
        .mem_memwrite_o(a_mem_memwrite), .mem_memtoreg_o(a_mem_memtoreg), .mem_rd_o(a_mem_rd)
    );

    decode_ctrl_pipe #(.ENABLE_AUIPC(1'b0), .ENABLE_MEXT(1'b0), .HAZARD_EN(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid_i(b_valid), .id_instr_i(b_instr),
        .flush_i(b_flush), .ex_ready_i(b_ready), .id_stall_o(b_stall),
        .ex_valid_o(b_ex_valid), .ex_regwrite_o(b_ex_regwrite), .ex_alusrc_o(b_ex_alusrc),
        .ex_memread_o(b_ex_memread), .ex_memwrite_o(b_ex_memwrite), .ex_memtoreg_o(b_ex_memtoreg),
        .ex_branch_o(b_ex_branch), .ex_jump_o(b_ex_jump), .ex_auipc_o(b_ex_auipc),
        .ex_illegal_o(b_ex_illegal), .ex_aluop_o(b_ex_aluop), .ex_insttype_o(b_ex_insttype),
        .ex_func3_o(b_ex_func3), .ex_rd_o(b_ex_rd), .ex_rs1_o(b_ex_rs1), .ex_rs2_o(b_ex_rs2),
        .mem_valid_o(b_mem_valid), .mem_regwrite_o(b_mem_regwrite), .mem_memread_o(b_mem_memread),
        .mem_memwrite_o(b_mem_memwrite), .mem_memtoreg_o(b_mem_memtoreg), .mem_rd_o(b_mem_rd)
    );

    exp_t       a_ex, b_ex;
    logic [9:0] a_mem, b_mem;

    assign a_ex = {a_ex_valid, a_ex_regwrite, a_ex_alusrc, a_ex_memread, a_ex_memwrite, a_ex_memtoreg,
                   a_ex_branch, a_ex_jump, a_ex_auipc, a_ex_illegal, a_ex_aluop, a_ex_insttype,
                   a_ex_func3, a_ex_rd, a_ex_rs1, a_ex_rs2};
    assign b_ex = {b_ex_valid, b_ex_regwrite, b_ex_alusrc, b_ex_memread, b_ex_memwrite, b_ex_memtoreg,
                   b_ex_branch, b_ex_jump, b_ex_auipc, b_ex_illegal, b_ex_aluop, b_ex_insttype,
                   b_ex_func3, b_ex_rd, b_ex_rs1, b_ex_rs2};
    assign a_mem = {a_mem_valid, a_mem_regwrite, a_mem_memread, a_mem_memwrite, a_mem_memtoreg, a_mem_rd};
    assign b_mem = {b_mem_valid, b_mem_regwrite, b_mem_memread, b_mem_memwrite, b_mem_memtoreg, b_mem_rd};

    int checks = 0;
    int errors = 0;

    exp_t       ex_q[$];
    logic [9:0] mem_q[$];
    exp_t       m_ex;
    bit         load_evt;
    exp_t       prev_ex;
    logic [9:0] prev_mem;
    exp_t       mon_e;
    exp_t       b_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] mem_of(input exp_t e);
        return {e.valid, e.regwrite, e.memread, e.memwrite, e.memtoreg, e.rd};
    endfunction

    // Reference decode straight from the opcode table.
    function automatic exp_t model_decode(input logic [31:0] ins, input bit mext, input bit auipc_en,
                                          output bit u1, output bit u2);
        exp_t e;
        logic [6:0] f7;
        f7 = ins[31:25];
        e = '0;
        e.valid = 1'b1;
        u1 = 1'b1;
        u2 = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                e.regwrite = 1'b1; u2 = 1'b1;
                if (f7 == 7'b0000000 || f7 == 7'b0100000) e.aluop = 3'b010;
                else if (mext && f7 == 7'b0000001) e.aluop = 3'b110;
                else e.illegal = 1'b1;
            end
            7'b0010011: begin e.aluop = 3'b011; e.alusrc = 1'b1; e.regwrite = 1'b1; e.insttype = 3'd1; end
            7'b0000011: begin
                e.alusrc = 1'b1; e.regwrite = 1'b1; e.memread = 1'b1; e.memtoreg = 1'b1; e.insttype = 3'd1;
            end
            7'b0100011: begin e.alusrc = 1'b1; e.memwrite = 1'b1; e.insttype = 3'd2; u2 = 1'b1; end
            7'b1100011: begin e.aluop = 3'b101; e.branch = 1'b1; e.insttype = 3'd3; u2 = 1'b1; end
            7'b0110111: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.insttype = 3'd4; u1 = 1'b0; end
            7'b0010111: begin
                if (auipc_en) begin
                    e.alusrc = 1'b1; e.regwrite = 1'b1; e.auipc = 1'b1; e.insttype = 3'd4; u1 = 1'b0;
                end else e.illegal = 1'b1;
            end
            7'b1101111: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.jump = 1'b1; e.insttype = 3'd5; u1 = 1'b0; end
            7'b1100111: begin e.alusrc = 1'b1; e.regwrite = 1'b1; e.jump = 1'b1; e.insttype = 3'd1; end
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) begin
            e = '0;
            e.valid = 1'b1;
            e.illegal = 1'b1;
            u1 = 1'b0;
            u2 = 1'b0;
        end
        e.func3 = ins[14:12];
        e.rd = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        if (e.rd == 5'd0) e.regwrite = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        logic [6:0] f7;
        case ($urandom_range(0, 10))
            0: op = 7'b0110011;  1: op = 7'b0010011;  2: op = 7'b0000011;
            3: op = 7'b0100011;  4: op = 7'b1100011;  5: op = 7'b0110111;
            6: op = 7'b0010111;  7: op = 7'b1101111;  8: op = 7'b1100111;
            9: op = 7'b0000011;  default: op = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'b0000000;  1: f7 = 7'b0100000;  2: f7 = 7'b0000001;
            default: f7 = 7'($urandom);
        endcase
        return enc(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                   5'($urandom_range(0, 3)), op);
    endfunction

    // One clock of stimulus on DUT A; the model decides stall and what enters EX.
    task automatic step(input logic [31:0] ins, input bit v, input bit fl, input bit rdy, output bit consumed);
        exp_t d;
        bit u1, u2, hz, exp_stall;
        a_instr = ins; a_valid = v; a_flush = fl; a_ready = rdy;
        d = model_decode(ins, 1'b1, 1'b1, u1, u2);
        hz = v && m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) &&
             ((u1 && d.rs1 == m_ex.rd) || (u2 && d.rs2 == m_ex.rd));
        exp_stall = !rdy || (hz && !fl);
        #2;
        check("id_stall", 64'(a_stall), 64'(exp_stall));
        @(posedge clk);
        load_evt = rdy;
        consumed = rdy && (fl || !hz);
        if (rdy) begin
            if (v && !fl && !hz) begin
                m_ex = d;
                ex_q.push_back(d);
                mem_q.push_back(mem_of(d));
            end else begin
                m_ex = '0;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        bit c;
        c = 1'b0;
        for (int k = 0; k < 4 && !c; k++) step(ins, 1'b1, 1'b0, 1'b1, c);
        if (!c) begin
            errors++;
            $display("FAIL issue_bound: instruction %h not accepted within 4 cycles", ins);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_ready = 1'b1;
        a_flush = 1'b0;
        #1;
        check("rst_ex", 64'(a_ex), 64'(0));
        check("rst_mem", 64'(a_mem), 64'(0));
        check("rst_stall", 64'(a_stall), 64'(0));
        m_ex = '0;
        ex_q.delete();
        mem_q.delete();
        @(posedge clk);
        load_evt = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic b_issue(input logic [31:0] ins, input string name);
        exp_t e;
        bit u1, u2;
        e = model_decode(ins, 1'b0, 1'b0, u1, u2);
        b_instr = ins; b_valid = 1'b1; b_flush = 1'b0; b_ready = 1'b1;
        #2;
        check({name, "_stall"}, 64'(b_stall), 64'(0));
        @(posedge clk);
        #2;
        check({name, "_ex"}, 64'(b_ex), 64'(e));
        check({name, "_mem"}, 64'(b_mem), 64'(mem_of(b_prev)));
        b_prev = e;
    endtask

    // Monitor: a register update pops the scoreboard; otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_evt) begin
                if (a_ex.valid) begin
                    if (ex_q.size() == 0) begin
                        errors++;
                        $display("FAIL ex_extra: unexpected valid %h", a_ex);
                    end else begin
                        mon_e = ex_q.pop_front();
                        check("ex_ctrl", 64'(a_ex), 64'(mon_e));
                    end
                end else begin
                    check("ex_bubble", 64'(a_ex), 64'(0));
                end
                if (a_mem[9]) begin
                    if (mem_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_extra: unexpected valid %h", a_mem);
                    end else begin
                        check("mem_ctrl", 64'(a_mem), 64'(mem_q.pop_front()));
                    end
                end else begin
                    check("mem_bubble", 64'(a_mem), 64'(0));
                end
            end else begin
                check("ex_hold", 64'(a_ex), 64'(prev_ex));
                check("mem_hold", 64'(a_mem), 64'(prev_mem));
            end
        end
        prev_ex = a_ex;
        prev_mem = a_mem;
    end

    initial begin
        bit c;
        bit rdy, fl, cur_v;
        logic [31:0] cur;
        rst_n = 1'b0;
        a_valid = 1'b0; a_flush = 1'b0; a_ready = 1'b1; a_instr = '0;
        b_valid = 1'b0; b_flush = 1'b0; b_ready = 1'b1; b_instr = '0;
        m_ex = '0; load_evt = 1'b0; b_prev = '0;
        #3;
        check("init_ex", 64'(a_ex), 64'(0));
        check("init_mem", 64'(a_mem), 64'(0));
        check("init_stall", 64'(a_stall), 64'(0));
        check("init_b_ex", 64'(b_ex), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));          // add x3,x1,x2
        issue(enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03));          // lw x5,0(x1)
        issue(enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33));          // add x6,x5,x2 (stalls once)
        issue(enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03));          // lw x0
        issue(enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd6, 7'h33));          // add x6,x0,x0: no stall
        issue(enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03));          // lw x5
        issue(enc(7'h00, 5'd4, 5'd7, 3'd0, 5'd6, 7'h33));          // unrelated: no stall
        issue(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63));          // beq x1,x2
        step(enc(7'h00, 5'd1, 5'd1, 3'd0, 5'd7, 7'h13), 1'b1, 1'b1, 1'b1, c);   // addi flushed
        issue(enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03));          // lw x5
        step(enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33), 1'b1, 1'b1, 1'b1, c);   // flush+hazard
        issue(enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03));          // lw x5
        for (int k = 0; k < 3; k++) step(enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33), 1'b1, 1'b1, 1'b0, c);
        step(enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33), 1'b1, 1'b0, 1'b1, c);   // hazard stall
        do_reset();                                                 // reset mid-stall
        issue(enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33));
        issue(enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33));          // mul
        issue(enc(7'h12, 5'd0, 5'd0, 3'd0, 5'd4, 7'h17));          // auipc
        issue(32'hFFFF_FFFF);                                       // opcode 1111111
        issue(enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd0, 7'h13));          // addi x0,x0,0

        cur = rand_instr();
        cur_v = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            rdy = ($urandom_range(0, 4) != 0);
            fl = ($urandom_range(0, 6) == 0);
            step(cur, cur_v, fl, rdy, c);
            if (c) begin
                cur = rand_instr();
                cur_v = ($urandom_range(0, 5) != 0);
            end
        end
        for (int k = 0; k < 4; k++) step(32'h0, 1'b0, 1'b0, 1'b1, c);
        check("ex_q_drained", 64'(ex_q.size()), 64'(0));
        check("mem_q_drained", 64'(mem_q.size()), 64'(0));

        b_issue(enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), "b_mul");
        b_issue(enc(7'h12, 5'd0, 5'd0, 3'd0, 5'd4, 7'h17), "b_auipc");
        b_issue(enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03), "b_lw");
        b_issue(enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33), "b_add_dep");
        b_issue(enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), "b_sub");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
